mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit with its own HI/LO registers.
- Takes MULT/MULTU/DIV/DIVU out of the single-cycle ALU result path. The ALU's combinational `*` and `/` paths are retired in favour of this block.
- Runs a fixed-latency radix-2 iteration: shift-add for multiply, restoring for divide.
- Drives a busy/stall signal to the pipeline control and exposes HI/LO for MFHI/MFLO.

---
 rtl/mdu_sequencer_pkg.sv | 23 ++
 rtl/mdu_sequencer_md_iter_step.sv | 37 +++
 rtl/mdu_sequencer.sv | 121 ++++++++++++
 tb/tb_mdu_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared op codes, FSM encodings and small decode helpers for the multiply/divide unit.
package mdu_sequencer_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_sequencer_md_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_shq,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_shq
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc} + (i_shq[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
    w_rem_sh = {i_acc, i_shq[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, i_b});
    // When the trial subtract succeeds the difference is below i_b, so WIDTH bits suffice.
    w_diff   = w_rem_sh[WIDTH-1:0] - i_b;
    o_acc    = w_sum[WIDTH:1];
    o_shq    = {w_sum[0], i_shq[WIDTH-1:1]};
    if (i_div) begin
      if (w_ge) begin
        o_acc = w_diff;
        o_shq = {i_shq[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_rem_sh[WIDTH-1:0];
        o_shq = {i_shq[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; runs on magnitudes and fixes signs at commit.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [2:0]       Md_op,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Operand_a,
  input  logic [WIDTH-1:0] Operand_b,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [1:0]       o_dbg_state
);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc, r_shq, r_b, r_hi, r_lo;
  logic               r_sa, r_sb, r_div, r_bzero, r_done;

  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_acc_nx, w_shq_nx, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  always_comb begin
    w_sa       = is_signed_op(Md_op) & Operand_a[WIDTH-1];
    w_sb       = is_signed_op(Md_op) & Operand_b[WIDTH-1];
    w_abs_a    = w_sa ? (-Operand_a) : Operand_a;
    w_abs_b    = w_sb ? (-Operand_b) : Operand_b;
    w_prod     = {r_acc, r_shq};
    w_prod_fix = (r_sa ^ r_sb) ? (-w_prod) : w_prod;
    // Divide by zero leaves the dividend in the remainder; only the quotient needs forcing.
    w_quo_fix  = r_bzero ? {WIDTH{1'b1}} : ((r_sa ^ r_sb) ? (-r_shq) : r_shq);
    w_rem_fix  = r_sa ? (-r_acc) : r_acc;
  end

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_shq (r_shq),
    .i_b   (r_b),
    .o_acc (w_acc_nx),
    .o_shq (w_shq_nx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_shq   <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_div   <= 1'b0;
      r_bzero <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start && !Flush) begin
            if (is_muldiv(Md_op)) begin
              r_state <= ST_CALC;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_acc   <= '0;
              r_shq   <= w_abs_a;
              r_b     <= w_abs_b;
              r_sa    <= w_sa;
              r_sb    <= w_sb;
              r_div   <= Md_op[1];
              r_bzero <= (Operand_b == '0);
            end else if (Md_op == MD_MTHI) begin
              r_hi <= Operand_a;
            end else if (Md_op == MD_MTLO) begin
              r_lo <= Operand_a;
            end
          end
        end
        ST_CALC: begin
          if (Flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_acc_nx;
            r_shq <= w_shq_nx;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) r_state <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          r_state <= ST_IDLE;
          if (!Flush) begin
            r_done <= 1'b1;
            if (r_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy        = (r_state != ST_IDLE);
  assign Done        = r_done;
  assign Hi          = r_hi;
  assign Lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed results, latency/Busy/Done timing, flush and reset cases.
module tb_mdu_sequencer;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         Start;
  logic [2:0]   Md_op;
  logic         Flush;
  logic [W-1:0] Operand_a, Operand_b;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0]  exp_q[$];
  logic [W-1:0] last_hi, last_lo;

  mdu_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .Start       (Start),
    .Md_op       (Md_op),
    .Flush       (Flush),
    .Operand_a   (Operand_a),
    .Operand_b   (Operand_b),
    .Busy        (Busy),
    .Done        (Done),
    .Hi          (Hi),
    .Lo          (Lo),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  // Issue one mul/div, optionally pulse a second Start while busy, then score the result.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int poke_at);
    int n;
    int busy_bad;
    logic [63:0] expv;
    @(negedge clock);
    Start = 1'b1; Md_op = op; Operand_a = a; Operand_b = b;
    exp_q.push_back({exp_hi, exp_lo});
    @(posedge clock); #1;
    Start = 1'b0; Operand_a = $urandom; Operand_b = $urandom;
    check_eq({tag, " done_low_after_start"}, {63'd0, Done}, 64'd0);
    n = 0; busy_bad = 0;
    while (!Done && n < 40) begin
      if (!Busy) busy_bad++;
      if (n == poke_at) begin
        Start = 1'b1; Md_op = OP_MULTU; Operand_a = 32'd2; Operand_b = 32'd2;
      end else begin
        Start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    Start = 1'b0;
    check_eq({tag, " latency"}, 64'(n), 64'd33);
    check_eq({tag, " busy_gaps"}, 64'(busy_bad), 64'd0);
    check_eq({tag, " busy_in_done"}, {63'd0, Busy}, 64'd0);
    expv = exp_q.pop_front();
    check_eq({tag, " hi"}, {32'd0, Hi}, {32'd0, expv[63:32]});
    check_eq({tag, " lo"}, {32'd0, Lo}, {32'd0, expv[31:0]});
    last_hi = exp_hi;
    last_lo = exp_lo;
  endtask

  task automatic move_to(input string tag, input logic [2:0] op, input logic [W-1:0] a);
    @(negedge clock);
    Start = 1'b1; Md_op = op; Operand_a = a;
    @(posedge clock); #1;
    Start = 1'b0;
    if (op == OP_MTHI) last_hi = a;
    if (op == OP_MTLO) last_lo = a;
    check_eq({tag, " hi"}, {32'd0, Hi}, {32'd0, last_hi});
    check_eq({tag, " lo"}, {32'd0, Lo}, {32'd0, last_lo});
    check_eq({tag, " busy"}, {63'd0, Busy}, 64'd0);
    check_eq({tag, " done"}, {63'd0, Done}, 64'd0);
  endtask

  initial begin
    int n_done;
    reset_n = 1'b0; Start = 1'b0; Md_op = 3'd0; Flush = 1'b0;
    Operand_a = '0; Operand_b = '0;
    last_hi = '0; last_lo = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset busy", {63'd0, Busy}, 64'd0);
    check_eq("reset done", {63'd0, Done}, 64'd0);
    check_eq("reset hi", {32'd0, Hi}, 64'd0);
    check_eq("reset lo", {32'd0, Lo}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Results, back-to-back (each Start lands in the previous Done cycle)
    run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    run_md("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
    run_md("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_md("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        -1);
    run_md("divu_zero", OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, -1);
    run_md("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, -1);
    run_md("div_zero",  OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);
    run_md("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
    run_md("div_negb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, -1);
    run_md("busy_poke", OP_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 15);

    // Moves to HI/LO and no-op codes
    move_to("mthi", OP_MTHI, 32'h0000_1234);
    move_to("mtlo", OP_MTLO, 32'h0000_ABCD);
    move_to("noop6", 3'd6, 32'h5A5A_5A5A);
    move_to("noop7", 3'd7, 32'hA5A5_A5A5);

    // Flush mid-CALC: Busy drops at the next edge, Hi/Lo keep their values
    @(negedge clock);
    Start = 1'b1; Md_op = OP_MULTU; Operand_a = 32'd3; Operand_b = 32'd4;
    @(posedge clock); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    check_eq("flush busy_before", {63'd0, Busy}, 64'd1);
    Flush = 1'b1;
    @(posedge clock); #1;
    Flush = 1'b0;
    check_eq("flush busy_after", {63'd0, Busy}, 64'd0);
    n_done = 0;
    repeat (40) begin @(posedge clock); #1; if (Done) n_done++; end
    check_eq("flush no_done", 64'(n_done), 64'd0);
    check_eq("flush hi", {32'd0, Hi}, {32'd0, last_hi});
    check_eq("flush lo", {32'd0, Lo}, {32'd0, last_lo});

    // Flush beats Start in IDLE
    @(negedge clock);
    Start = 1'b1; Flush = 1'b1; Md_op = OP_MTLO; Operand_a = 32'h5555_0000;
    @(posedge clock); #1;
    check_eq("flush_start mtlo", {32'd0, Lo}, {32'd0, last_lo});
    @(negedge clock);
    Md_op = OP_DIVU; Operand_a = 32'd9; Operand_b = 32'd3;
    @(posedge clock); #1;
    Start = 1'b0; Flush = 1'b0;
    check_eq("flush_start busy", {63'd0, Busy}, 64'd0);

    // Asynchronous reset in the middle of CALC
    @(negedge clock);
    Start = 1'b1; Md_op = OP_MULTU; Operand_a = 32'd6; Operand_b = 32'd7;
    @(posedge clock); #1;
    Start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    check_eq("areset busy", {63'd0, Busy}, 64'd0);
    check_eq("areset done", {63'd0, Done}, 64'd0);
    check_eq("areset hi", {32'd0, Hi}, 64'd0);
    check_eq("areset lo", {32'd0, Lo}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    last_hi = '0; last_lo = '0;
    run_md("after_reset", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
